// File: rtl/wb_pkg.sv
// Shared types, default sizes and the block-alignment helper for write_back_buffer.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } wb_state_t;

    localparam int WB_ADDR_LENGTH   = 10;
    localparam int WB_BLOCK_SIZE    = 32;
    localparam int WB_DEPTH         = 4;
    localparam int BYTE_SELECT_SIZE = $clog2(WB_BLOCK_SIZE / 8);
    localparam int ADDR_MAX         = 32;

    // Callers zero-extend narrower addresses to ADDR_MAX and truncate the result back.
    function automatic logic [ADDR_MAX-1:0] block_align(input logic [ADDR_MAX-1:0] addr,
                                                        input int bsel_w);
        logic [ADDR_MAX-1:0] mask;
        mask = {ADDR_MAX{1'b1}} << bsel_w;
        return addr & mask;
    endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Per-entry block-address comparator with youngest-entry priority (entry closest to tail wins).
module wb_addr_match
#(
    parameter int ADDR_LENGTH = 10,
    parameter int DEPTH       = 4,
    parameter int PTR_W       = 2
) (
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH*ADDR_LENGTH-1:0] addr_i,
    input  logic [ADDR_LENGTH-1:0]       probe_i,
    input  logic [PTR_W-1:0]             tail_i,
    output logic                         hit_o,
    output logic [PTR_W-1:0]             hit_idx_o,
    output logic [DEPTH-1:0]             match_o
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign match_o[gi] = valid_i[gi] &&
                             (addr_i[gi*ADDR_LENGTH +: ADDR_LENGTH] == probe_i);
    end

    // Walk from oldest (tail-DEPTH == tail) to youngest (tail-1); the last match seen wins.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (match_o[tail_i - PTR_W'(k)]) begin
                hit_o     = 1'b1;
                hit_idx_o = tail_i - PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/write_back_buffer.sv
// FIFO of dirty evicted blocks drained to the lower level through a req/ack FSM, with a
// combinational lookup port. Define WB_COALESCE_EN to merge pushes into matching entries.
module write_back_buffer
    import wb_pkg::*;
#(
    parameter int ADDR_LENGTH = WB_ADDR_LENGTH,
    parameter int BLOCK_SIZE  = WB_BLOCK_SIZE,
    parameter int DEPTH       = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_enable_in,
    input  logic [ADDR_LENGTH-1:0]   wb_addr_in,
    input  logic [BLOCK_SIZE-1:0]    wb_data_in,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic [ADDR_LENGTH-1:0]   lookup_addr,
    output logic                     lookup_hit,
    output logic [BLOCK_SIZE-1:0]    lookup_data,
    output logic                     mem_write,
    output logic [ADDR_LENGTH-1:0]   mem_addr,
    output logic [BLOCK_SIZE-1:0]    mem_data,
    input  logic                     mem_ack
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BSEL_W = $clog2(BLOCK_SIZE / 8);

    function automatic logic [ADDR_LENGTH-1:0] align_addr(input logic [ADDR_LENGTH-1:0] a);
        return ADDR_LENGTH'(block_align(ADDR_MAX'(a), BSEL_W));
    endfunction

    logic [DEPTH-1:0]             valid_q;
    logic [ADDR_LENGTH-1:0]       addr_q [DEPTH];
    logic [BLOCK_SIZE-1:0]        data_q [DEPTH];
    logic [PTR_W-1:0]             head_q;
    logic [PTR_W-1:0]             tail_q;
    logic [PTR_W:0]               count_q;
    logic [PTR_W:0]               count_d;
    logic                         overflow_q;
    logic                         mem_write_q;
    wb_state_t                    state_q;

    logic [DEPTH*ADDR_LENGTH-1:0] addr_flat;
    logic [ADDR_LENGTH-1:0]       push_addr;
    logic                         do_pop;
    logic                         do_merge;
    logic                         do_alloc;
    logic                         do_drop;
    logic [PTR_W-1:0]             merge_idx;
    logic                         lk_hit;
    logic [PTR_W-1:0]             lk_idx;
    logic [DEPTH-1:0]             lk_match;
    logic                         unused_match;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
        assign addr_flat[gi*ADDR_LENGTH +: ADDR_LENGTH] = addr_q[gi];
    end

    assign push_addr = align_addr(wb_addr_in);

    wb_addr_match #(
        .ADDR_LENGTH (ADDR_LENGTH),
        .DEPTH       (DEPTH),
        .PTR_W       (PTR_W)
    ) u_lookup_match (
        .valid_i   (valid_q),
        .addr_i    (addr_flat),
        .probe_i   (align_addr(lookup_addr)),
        .tail_i    (tail_q),
        .hit_o     (lk_hit),
        .hit_idx_o (lk_idx),
        .match_o   (lk_match)
    );

`ifdef WB_COALESCE_EN
    logic [DEPTH-1:0] co_valid;
    logic             co_hit;
    logic [PTR_W-1:0] co_idx;
    logic [DEPTH-1:0] co_match;

    // The head being offered to the lower level is frozen, so it is not a merge target.
    always_comb begin
        co_valid = valid_q;
        if (state_q == REQ) begin
            co_valid[head_q] = 1'b0;
        end
    end

    wb_addr_match #(
        .ADDR_LENGTH (ADDR_LENGTH),
        .DEPTH       (DEPTH),
        .PTR_W       (PTR_W)
    ) u_coalesce_match (
        .valid_i   (co_valid),
        .addr_i    (addr_flat),
        .probe_i   (push_addr),
        .tail_i    (tail_q),
        .hit_o     (co_hit),
        .hit_idx_o (co_idx),
        .match_o   (co_match)
    );

    assign do_merge     = wb_enable_in && co_hit;
    assign merge_idx    = co_idx;
    assign unused_match = ^{lk_match, co_match};
`else
    assign do_merge     = 1'b0;
    assign merge_idx    = '0;
    assign unused_match = ^lk_match;
`endif

    // full comes from pre-edge state, so a same-edge pop never makes room for a push.
    assign do_pop   = mem_write_q && mem_ack;
    assign do_alloc = wb_enable_in && !do_merge && !full;
    assign do_drop  = wb_enable_in && !do_merge && full;
    assign count_d  = count_q + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= push_addr;
                data_q[tail_q]  <= wb_data_in;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (do_merge) begin
                data_q[merge_idx] <= wb_data_in;
            end
            if (do_drop) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q     <= REQ;
                        mem_write_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_q     <= GAP;
                        mem_write_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (count_q != '0) begin
                        state_q     <= REQ;
                        mem_write_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Head cannot move or be merged while mem_write is high, so these stay stable in REQ.
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_write_q ? addr_q[head_q] : '0;
    assign mem_data    = mem_write_q ? data_q[head_q] : '0;
    assign full        = (count_q == (PTR_W+1)'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign lookup_hit  = lk_hit;
    assign lookup_data = lk_hit ? data_q[lk_idx] : '0;

endmodule

// File: tb/tb_write_back_buffer.sv
// Directed scoreboard bench for write_back_buffer: drains are queued at push time and checked
// by a monitor on each mem_write/mem_ack handshake.
module tb_write_back_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_enable_in = 1'b0;
    logic [9:0]  wb_addr_in = '0;
    logic [31:0] wb_data_in = '0;
    logic        full, empty, overflow;
    logic [2:0]  count;
    logic [9:0]  lookup_addr = '0;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic        mem_write;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack = 1'b0;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } drain_t;

    drain_t exp_q[$];
    int     hs_times[$];
    int     n_pass = 0;
    int     n_total = 0;
    int     cyc = 0;

    write_back_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .wb_enable_in (wb_enable_in),
        .wb_addr_in   (wb_addr_in),
        .wb_data_in   (wb_data_in),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .lookup_data  (lookup_data),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ack      (mem_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] a, input logic [31:0] d);
        wb_enable_in = 1'b1;
        wb_addr_in   = a;
        wb_data_in   = d;
        tick();
        wb_enable_in = 1'b0;
    endtask

    task automatic expect_drain(input logic [9:0] a, input logic [31:0] d);
        drain_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: inputs are stable at the falling edge, so this sees exactly the handshakes.
    always @(negedge clk) begin
        if (reset && mem_write && mem_ack) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_drain: got addr 0x%0h, expected no drain", mem_addr);
            end else begin
                drain_t e;
                e = exp_q.pop_front();
                $display("drain cyc=%0d addr=0x%0h data=0x%0h", cyc, mem_addr, mem_data);
                check("drain_addr", 64'(mem_addr), 64'(e.addr));
                check("drain_data", 64'(mem_data), 64'(e.data));
                hs_times.push_back(cyc);
            end
        end
    end

    logic [9:0]  fill_addr [5] = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h010};
    logic [31:0] fill_data [5] = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008,
                                   32'h4444_000C, 32'h5555_0010};

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_data", 64'(mem_data), 64'd0);
        reset = 1'b1;
        tick();

        // Single push, latency, stable hold, ack
        push(10'h013, 32'hDEADBEEF);
        expect_drain(10'h010, 32'hDEADBEEF);
        check("t1_empty_after_push", 64'(empty), 64'd0);
        check("t1_mem_write_not_yet", 64'(mem_write), 64'd0);
        tick();
        check("t1_mem_write_rise", 64'(mem_write), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_hold_addr", 64'(mem_addr), 64'h010);
            check("t1_hold_data", 64'(mem_data), 64'hDEADBEEF);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t1_count_after_ack", 64'(count), 64'd0);
        check("t1_gap_mem_write", 64'(mem_write), 64'd0);
        tick();
        check("t1_idle_mem_write", 64'(mem_write), 64'd0);
        tick();

        // Fill to full, overflow, drain order and rate
        for (int i = 0; i < 4; i++) begin
            push(fill_addr[i], fill_data[i]);
            expect_drain(fill_addr[i], fill_data[i]);
        end
        check("t2_full", 64'(full), 64'd1);
        check("t2_count4", 64'(count), 64'd4);
        check("t2_no_overflow_yet", 64'(overflow), 64'd0);
        push(fill_addr[4], fill_data[4]);
        check("t2_overflow", 64'(overflow), 64'd1);
        check("t2_count_after_drop", 64'(count), 64'd4);
        hs_times.delete();
        mem_ack = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        mem_ack = 1'b0;
        check("t2_count_drained", 64'(count), 64'd0);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t2_drain_count", 64'(hs_times.size()), 64'd4);
        for (int i = 1; i < hs_times.size(); i++)
            check("t2_drain_spacing", 64'(hs_times[i] - hs_times[i-1]), 64'd2);
        check("t2_overflow_sticky", 64'(overflow), 64'd1);
        tick();
        tick();

        // Lookup
        lookup_addr  = 10'h022;
        wb_enable_in = 1'b1;
        wb_addr_in   = 10'h020;
        wb_data_in   = 32'hCAFE0020;
        #1;
        check("t3_push_not_visible", 64'(lookup_hit), 64'd0);
        tick();
        wb_enable_in = 1'b0;
        expect_drain(10'h020, 32'hCAFE0020);
        check("t3_hit", 64'(lookup_hit), 64'd1);
        check("t3_hit_data", 64'(lookup_data), 64'hCAFE0020);
        lookup_addr = 10'h024;
        #1;
        check("t3_miss", 64'(lookup_hit), 64'd0);
        check("t3_miss_data", 64'(lookup_data), 64'd0);
        lookup_addr = 10'h022;
        tick();
        tick();
        check("t3_hit_in_req", 64'(lookup_hit), 64'd1);
        mem_ack = 1'b1;
        #1;
        check("t3_hit_before_ack_edge", 64'(lookup_hit), 64'd1);
        tick();
        mem_ack = 1'b0;
        check("t3_miss_after_pop", 64'(lookup_hit), 64'd0);
        tick();
        tick();

        // Simultaneous push and pop
        push(10'h100, 32'hA000_0100);
        expect_drain(10'h100, 32'hA000_0100);
        push(10'h104, 32'hA000_0104);
        expect_drain(10'h104, 32'hA000_0104);
        check("t4_count2", 64'(count), 64'd2);
        check("t4_req", 64'(mem_write), 64'd1);
        wb_enable_in = 1'b1;
        wb_addr_in   = 10'h108;
        wb_data_in   = 32'hA000_0108;
        mem_ack      = 1'b1;
        tick();
        wb_enable_in = 1'b0;
        mem_ack      = 1'b0;
        expect_drain(10'h108, 32'hA000_0108);
        check("t4_count_unchanged", 64'(count), 64'd2);
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        mem_ack = 1'b0;
        check("t4_drained", 64'(count), 64'd0);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();
        tick();

        // Duplicate address
        push(10'h040, 32'hAAAA0040);
        push(10'h040, 32'hBBBB0040);
        lookup_addr = 10'h040;
        #1;
        check("t5_lookup_youngest", 64'(lookup_data), 64'hBBBB0040);
`ifdef WB_COALESCE_EN
        check("t5_count", 64'(count), 64'd1);
        expect_drain(10'h040, 32'hBBBB0040);
`else
        check("t5_count", 64'(count), 64'd2);
        expect_drain(10'h040, 32'hAAAA0040);
        expect_drain(10'h040, 32'hBBBB0040);
`endif
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        mem_ack = 1'b0;
        check("t5_drained", 64'(count), 64'd0);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();
        tick();

        // Asynchronous reset mid-drain
        push(10'h200, 32'hC000_0200);
        push(10'h204, 32'hC000_0204);
        push(10'h208, 32'hC000_0208);
        lookup_addr = 10'h204;
        #1;
        check("t6_count3", 64'(count), 64'd3);
        check("t6_mem_write", 64'(mem_write), 64'd1);
        check("t6_hit_before", 64'(lookup_hit), 64'd1);
        check("t6_overflow_before", 64'(overflow), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("t6_count", 64'(count), 64'd0);
        check("t6_empty", 64'(empty), 64'd1);
        check("t6_full", 64'(full), 64'd0);
        check("t6_overflow", 64'(overflow), 64'd0);
        check("t6_mem_write", 64'(mem_write), 64'd0);
        check("t6_mem_addr", 64'(mem_addr), 64'd0);
        check("t6_mem_data", 64'(mem_data), 64'd0);
        check("t6_hit", 64'(lookup_hit), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("t6_idle_after_release", 64'(mem_write), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/write_back_buffer.md
Name: write_back_buffer

Overview:
- Sits between an associative cache's write-back outputs and the next lower level (L2 cache or main memory).
- Captures dirty evicted blocks (address plus full block data) into a small FIFO and drains them to the lower level with a request/ack handshake.
- Provides a combinational lookup port, so the cache miss path can forward a block still held in the buffer instead of reading stale lower-level data.

Parameters:
- ADDR_LENGTH, 10, address width in bits.
- BLOCK_SIZE, 32, block width in bits; BYTE_SELECT_SIZE = $clog2(BLOCK_SIZE/8).
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- wb_enable_in  input  1  push strobe from the cache (one block per asserted cycle).
- wb_addr_in  input  ADDR_LENGTH  address of the evicted block.
- wb_data_in  input  BLOCK_SIZE  evicted block data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- overflow  output  1  sticky flag: a push was dropped.
- lookup_addr  input  ADDR_LENGTH  address probed by the cache miss path.
- lookup_hit  output  1  a valid entry matches lookup_addr.
- lookup_data  output  BLOCK_SIZE  data of the matching entry; 0 when no hit.
- mem_write  output  1  drain request to the lower level.
- mem_addr  output  ADDR_LENGTH  block-aligned address of the head entry.
- mem_data  output  BLOCK_SIZE  head entry data.
- mem_ack  input  1  lower level accepted the request; sampled only while mem_write=1.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - all entries invalid; head and tail pointers 0; count=0; empty=1; full=0; overflow=0.
  - mem_write=0; mem_addr=0; mem_data=0; FSM=IDLE.
  - Reset mid-drain abandons the transfer; buffered data is lost.
- Addresses:
  - Stored and compared block-aligned: the low BYTE_SELECT_SIZE bits are forced to 0.
  - mem_addr always has those bits 0.
- Push:
  - On a rising edge with wb_enable_in=1 and full=0, write {aligned address, data} at tail, advance tail (wraps DEPTH-1 to 0), count+1.
  - Push while full is dropped: overflow set to 1 and held until reset; no other state change.
- Drain FSM (registered):
  - IDLE: if empty=0, go to REQ.
  - REQ: mem_write=1; mem_addr/mem_data are the head entry, held stable. On mem_ack=1, pop the head (invalidate it, advance head, count-1) and go to GAP.
  - GAP: mem_write=0 for exactly one cycle. Then REQ if the buffer is non-empty after the pop, else IDLE.
- Latency and throughput:
  - Push at edge N into an empty buffer: empty=0 after N; FSM enters REQ at N+1, so mem_write is high in the cycle after N+1.
  - Minimum drain throughput: one entry per 2 cycles.
- Simultaneous push and pop on the same edge: both occur; count unchanged.
  - full is evaluated from pre-edge state, so a push while full is dropped even if a pop happens on the same edge.
- Lookup (combinational, no clock):
  - Compare aligned lookup_addr against all valid entries; the youngest matching entry (closest to tail) wins.
  - The head entry in REQ still counts as a hit until its pop edge.
  - A push in the current cycle is not visible until after the edge.
- mem_ack while mem_write=0 is ignored.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined:
  - A push whose aligned address matches a valid entry overwrites that entry's data in place; count unchanged, not treated as overflow even when full.
  - Exception: if the only match is the head while FSM=REQ, its data is frozen and a new entry is allocated (normal push rules, including overflow).
- Not defined: every push allocates a new entry; duplicate addresses can coexist and lookup returns the youngest.

Decomposition:
- Package wb_pkg:
  - wb_state_t enum (IDLE, REQ, GAP).
  - localparam BYTE_SELECT_SIZE.
  - function block_align(addr) returning addr with low BYTE_SELECT_SIZE bits zeroed.
- Sub-module wb_addr_match:
  - Per-entry comparator plus youngest-priority select.
  - Produces a hit flag, a hit index and a one-hot match vector; used for both the lookup port and coalescing.

Test Plan:
- Reset, then push addr 10'h013, data 32'hDEADBEEF:
  - empty falls after that edge; mem_write rises one cycle later.
  - mem_addr=10'h010, mem_data=32'hDEADBEEF.
  - Hold mem_ack=0 for 5 cycles: outputs stay stable. mem_ack=1: count returns to 0, mem_write low in GAP, FSM back to IDLE.
- Push 4 blocks (addr 0x000, 0x004, 0x008, 0x00C) with mem_ack=0:
  - full=1, count=4.
  - 5th push addr 0x010: dropped, overflow=1 until reset.
  - Drain order with mem_ack=1: 0x000, 0x004, 0x008, 0x00C, one entry every 2 cycles.
- Lookup:
  - With addr 0x020 buffered, lookup_addr=10'h022: lookup_hit=1, lookup_data equals the buffered data in the same cycle.
  - lookup_addr=0x024: hit=0, data=0.
  - Hit persists on 0x020 until the ack edge of its drain.
- With count=2 and FSM in REQ, assert wb_enable_in and mem_ack on the same edge: count stays 2; the new entry drains after the remaining one.
- Without WB_COALESCE_EN:
  - Push 0x040/data A, then 0x040/data B: count=2; lookup returns B; both drain, A first.
  - With WB_COALESCE_EN (0x040 not at the head in REQ): count=1 and a single drain of B.
- Assert reset (reset=0) while mem_write=1 and count=3: all outputs return to reset values immediately, without waiting for a clock edge.
